cdc_fifo_read_ctrl: RTL

Read-side sequencer for the CDC FIFO's pop interface (data, empty, req) in the read clock domain.
- Issues pop requests and absorbs the FIFO's one-cycle registered RAM read latency.
- Presents the words as a valid/ready stream with burst framing (last flag every BURST_LEN words).
- Supports run/stop control and flush.
- Sits between the CDC FIFO read port and downstream consumers, e.g. video/audio output engines.

---
 rtl/cdc_fifo_read_ctrl_pkg.sv | 13 +
 rtl/cdc_fifo_read_ctrl_stream_fifo2.sv | 56 +++++
 rtl/cdc_fifo_read_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/cdc_fifo_read_ctrl_pkg.sv
// Shared types and constants for the CDC FIFO read-side sequencer.
// Holds FSM state encoding and output buffer sizing.
package cdc_fifo_read_ctrl_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  localparam int BUF_DEPTH = 2;
  localparam int OCC_WIDTH = 2;

endpackage

// File: rtl/cdc_fifo_read_ctrl_stream_fifo2.sv
// stream_fifo2: 2-entry registered FIFO buffering captured words.
// Ports: clk, reset, clear, wr/wdata in, rd/rdata out, count, valid.
module stream_fifo2
  import cdc_fifo_read_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [OCC_WIDTH-1:0]  count,
  output logic                  valid
);

  logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
  logic                  r_wptr;
  logic                  r_rptr;
  logic [OCC_WIDTH-1:0]  r_count;
  logic                  w_rd;

  assign w_rd  = rd & (r_count != '0);
  assign rdata = r_mem[r_rptr];
  assign count = r_count;
  assign valid = (r_count != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= '0;
    end else if (clear) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= '0;
    end else begin
      if (wr) begin
        r_mem[r_wptr] <= wdata;
        r_wptr        <= ~r_wptr;
      end
      if (w_rd) begin
        r_rptr <= ~r_rptr;
      end
      r_count <= r_count
               + OCC_WIDTH'(wr)
               - OCC_WIDTH'(w_rd);
    end
  end

endmodule

// File: rtl/cdc_fifo_read_ctrl.sv
// Read-side sequencer: pops the CDC FIFO, absorbs its 1-cycle RAM
// latency, and emits a valid/ready stream with burst last framing.
// Ports: clk/reset; fifo_data/fifo_empty/fifo_req (FIFO pop side);
// enable/flush control; m_data/m_valid/m_ready/m_last stream; busy.
module cdc_fifo_read_ctrl
  import cdc_fifo_read_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int BURST_LEN   = 16,
  parameter int BURST_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  output logic                  fifo_req,
  input  logic                  enable,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy
);

  localparam logic [BURST_WIDTH-1:0] LP_LAST =
    BURST_WIDTH'(BURST_LEN - 1);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_inflight;
  logic [BURST_WIDTH-1:0] r_burst_cnt;

  logic [OCC_WIDTH-1:0]   w_occ;
  logic                   w_buf_valid;
  logic                   w_hs;
  logic                   w_req;
  logic                   w_wr;
  logic                   w_clear;
  logic                   w_accept;
  logic [2:0]             w_credit;

  stream_fifo2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk   (clk),
    .reset (reset),
    .clear (w_clear),
    .wr    (w_wr),
    .wdata (fifo_data),
    .rd    (w_hs),
    .rdata (m_data),
    .count (w_occ),
    .valid (w_buf_valid)
  );

  assign m_valid = w_buf_valid;
  assign w_hs    = w_buf_valid & m_ready;
  assign m_last  = w_buf_valid & (r_burst_cnt == LP_LAST);

  // Slots already committed after this cycle's consumer pop.
  assign w_credit = {1'b0, w_occ}
                  + {2'b00, r_inflight}
                  - {2'b00, w_hs};

  // Gated by reset so no word is popped and then forgotten.
  assign fifo_req = w_req & ~reset;
  assign w_accept = fifo_req & ~fifo_empty;

  assign busy = w_buf_valid
              | r_inflight
              | (r_state == ST_FLUSH);

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_wr        = 1'b0;
    w_clear     = 1'b0;
    unique case (r_state)
      ST_RUN: begin
        w_req = enable & ~fifo_empty
              & (w_credit < 3'd2);
        w_wr  = r_inflight;
        if (flush) begin
          // Clear wins over this edge's capture.
          w_clear     = 1'b1;
          w_state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // Stay until the last in-flight word lands and is dropped.
        w_clear = 1'b1;
        if (!r_inflight) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_inflight  <= 1'b0;
      r_burst_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_accept;
      if (w_clear) begin
        r_burst_cnt <= '0;
      end else if (w_hs) begin
        if (m_last) begin
          r_burst_cnt <= '0;
        end else begin
          r_burst_cnt <= r_burst_cnt + BURST_WIDTH'(1);
        end
      end
    end
  end

endmodule
